accum_dump: RTL and testbench
=============================

Name: accum_dump

Overview:
- Integrate-and-dump accumulator that sits directly upstream of the half-up rounding stage.
- Sums CNT consecutive input samples and emits one widened sum per frame on a valid/ready output.
- The rounding stage then drops LSBs from that sum.
- Output is registered; the sum width guarantees no overflow.

Parameters:
- DIN, 16, input sample width in bits.
- CNT, 4, samples per output frame; legal range 1..65535.
- SIGNED, 1, 1 = two's-complement samples (sign-extend), 0 = unsigned (zero-extend).
- DOUT, DIN+$clog2(CNT), output width. Derived; must not be overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- din_ready  output  1  stage accepts din this cycle.
- din_valid  input  1  din_data valid.
- din_data  input  DIN  input sample.
- dout_ready  input  1  consumer accepts dout.
- dout_valid  output  1  dout_data holds a completed sum.
- dout_data  output  DOUT  frame sum.

Behaviour:
- State:
  - acc: DOUT bits, partial sum.
  - cnt: $clog2(CNT)+1 bits, samples taken in current frame, range 0..CNT-1.
  - out_reg: DOUT bits.
  - out_vld: 1 bit.
- Reset (rst=0, async): acc=0, cnt=0, out_vld=0, out_reg=0, so dout_valid=0 and dout_data=0.
  - Reset mid-frame discards the partial sum and any pending output.
  - First frame after release starts at cnt=0.
- Extension: din_data is extended to DOUT per SIGNED before addition. All arithmetic is DOUT-wide, modulo 2^DOUT; no overflow is possible by construction.
- Input transfer: din_valid & din_ready. Output transfer: dout_valid & dout_ready.
- last = (cnt == CNT-1).
- din_ready = !last | !out_vld | dout_ready. Only the frame-closing sample can stall, and only when the output register is full and not draining.
- On input transfer with !last: acc <= acc + ext(din), cnt <= cnt+1.
- On input transfer with last: out_reg <= acc + ext(din), out_vld <= 1, acc <= 0, cnt <= 0.
  - Latency: dout_valid rises the cycle after the closing sample.
- On output transfer with no simultaneous closing input transfer: out_vld <= 0. out_reg holds its value.
- Simultaneous output transfer and closing input transfer: out_reg is reloaded, out_vld stays 1. Full throughput, no bubble.
- dout_data = out_reg. It is stable while dout_valid=1 and dout_ready=0 (valid/ready rule: no retraction, no change).
- din_ready depends combinationally on dout_ready. There is no combinational path from din_valid to any output.
- CNT=1: every sample is "last". The block becomes a 1-deep registered pass-through with extension (DOUT=DIN).
- din_data is ignored when din_valid=0. acc and cnt change only on input transfer.

Decomposition:
- No shared package is needed.
- $clog2 is used directly for DOUT and the cnt width.
- Single flat module; no sub-module. The output register plus valid is too small to split out.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with din_valid=1 -> dout_valid=0, dout_data=0, no output; after release, din_ready=1.
- Unsigned frames (DIN=16, CNT=4, SIGNED=0):
  - Stimulus: dout_ready=1; din = 0xFFFF x4, then 1,2,3,4.
  - Required: dout = 0x3FFFC (18 bits), then 10.
  - Each dout_valid pulse appears exactly 1 cycle after the 4th sample.
- Signed extension (SIGNED=1, CNT=4): din = 0x8000 x4 -> dout = 0x20000 (−131072). Also din = −1,−1,1,0 -> dout = 0x3FFFF (−1).
- Backpressure:
  - Stimulus: dout_ready=0 after the first frame completes; keep din_valid=1.
  - Required: 3 more samples accepted, then din_ready=0 on the 4th; dout_data unchanged.
  - Then raise dout_ready for 1 cycle: first sum consumed, 4th sample accepted in the same cycle, second sum valid on the next cycle.
- Full throughput: din_valid=1 and dout_ready=1 continuously for 40 samples -> 10 outputs, din_ready never low, sums match the reference model.
- Mid-frame reset:
  - Stimulus: feed 2 samples of 5, pulse rst low for 1 cycle, then feed 7,7,7,7.
  - Required: dout = 28; no output containing the 5s.
- Random stimulus: random din_valid/dout_ready, CNT=3, SIGNED=1, 1000 samples -> scoreboard match.
  - Assert dout_data stable while dout_valid & !dout_ready.

Source files
------------

// File: rtl/accum_dump.sv
// accum_dump: integrate-and-dump accumulator; sums CNT samples into one widened,
// registered frame sum presented on a valid/ready output.
module accum_dump #(
   parameter int DIN = 16,
   parameter int CNT = 4,
   parameter bit SIGNED = 1'b1,
   localparam int DOUT = DIN + $clog2(CNT)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            din_ready,
   input  logic            din_valid,
   input  logic [DIN-1:0]  din_data,
   input  logic            dout_ready,
   output logic            dout_valid,
   output logic [DOUT-1:0] dout_data
);
   localparam int CW = $clog2(CNT) + 1;
   logic [DOUT-1:0] acc_q, acc_d, out_q, out_d, ext, sum;
   logic [CW-1:0] cnt_q, cnt_d;
   logic vld_q, vld_d, last, in_xfer, out_xfer;
   assign ext = SIGNED ? DOUT'(signed'(din_data)) : DOUT'(din_data);
   assign sum = acc_q + ext;
   assign last = cnt_q == CW'(CNT - 1);
   // only the frame-closing sample can stall, and only behind an undrained output
   assign din_ready = !last || !vld_q || dout_ready;
   assign in_xfer = din_valid && din_ready;
   assign out_xfer = vld_q && dout_ready;
   assign dout_valid = vld_q;
   assign dout_data = out_q;
   always_comb begin
      acc_d = in_xfer ? (last ? '0 : sum) : acc_q;
      cnt_d = in_xfer ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
      out_d = (in_xfer && last) ? sum : out_q;
      vld_d = (in_xfer && last) ? 1'b1 : (out_xfer ? 1'b0 : vld_q);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         out_q <= '0;
         vld_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         out_q <= out_d;
         vld_q <= vld_d;
      end
   end
endmodule

// File: tb/tb_accum_dump.sv
// tb_accum_dump: four accum_dump configurations share one stimulus stream; each
// has a frame-sum reference model feeding a queue popped by its own monitor.
module tb_accum_dump;
   logic clk = 1'b0, rst = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
   logic [15:0] din_data = '0;
   int cmp = 0, mism = 0;
   localparam int CN [4] = '{4, 4, 3, 1};
   localparam bit SG [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      cmp++;
      if (a !== e) begin
         mism++;
         $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : gen
      localparam int W = 16 + $clog2(CN[g]);
      logic rdy, vld, pv = 1'b0;
      logic [W-1:0] dd, pd, last_out = '0;
      longint fr[$];
      logic [W-1:0] q[$];
      int nout = 0;
      longint s;
      accum_dump #(.DIN(16), .CNT(CN[g]), .SIGNED(SG[g])) dut (
         .clk(clk), .rst(rst), .din_ready(rdy), .din_valid(din_valid), .din_data(din_data),
         .dout_ready(dout_ready), .dout_valid(vld), .dout_data(dd));
      always @(negedge clk) begin
         if (!rst) begin
            chk($sformatf("u%0d_rst_valid", g), 64'(vld), 64'(0));
            chk($sformatf("u%0d_rst_data", g), 64'(dd), 64'(0));
            pv <= 1'b0;
         end else begin
            if (pv) begin
               chk($sformatf("u%0d_hold_valid", g), 64'(vld), 64'(1));
               chk($sformatf("u%0d_hold_data", g), 64'(dd), 64'(pd));
            end
            chk($sformatf("u%0d_valid", g), 64'(vld), 64'(q.size() > 0));
            if (vld && q.size() > 0) begin
               chk($sformatf("u%0d_dout", g), 64'(dd), 64'(q[0]));
               if (dout_ready) begin
                  last_out <= dd;
                  nout <= nout + 1;
                  void'(q.pop_front());
               end
            end
            pv <= vld && !dout_ready;
            pd <= dd;
         end
      end
      always begin
         @(negedge clk);
         #1;
         if (!rst) begin
            fr.delete();
            q.delete();
         end else begin
            chk($sformatf("u%0d_din_ready", g), 64'(rdy),
                64'(!(fr.size() == CN[g] - 1 && q.size() > 0 && !dout_ready)));
            if (din_valid && rdy) begin
               fr.push_back(SG[g] ? longint'($signed(din_data)) : longint'(din_data));
               if (fr.size() == CN[g]) begin
                  s = 0;
                  foreach (fr[i]) s += fr[i];
                  q.push_back(W'(s));
                  fr.delete();
               end
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [15:0] d, input bit r);
      @(posedge clk);
      #1;
      din_valid = v;
      din_data = d;
      dout_ready = r;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 16'h0, 1'b1);
   endtask

   initial begin
      int n0;
      din_valid = 1'b1;
      din_data = 16'h1234;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      din_valid = 1'b0;
      dout_ready = 1'b1;
      #1;
      chk("ready_after_reset", 64'(gen[0].rdy), 64'(1));
      repeat (4) drive(1'b1, 16'hFFFF, 1'b1);
      idle(2);
      chk("u0_ffff", 64'(gen[0].last_out), 64'h3FFFC);
      chk("u1_neg4", 64'(gen[1].last_out), 64'h3FFFC);
      for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i), 1'b1);
      idle(2);
      chk("u0_ten", 64'(gen[0].last_out), 64'd10);
      repeat (4) drive(1'b1, 16'h8000, 1'b1);
      idle(2);
      chk("u1_min", 64'(gen[1].last_out), 64'h20000);
      drive(1'b1, 16'hFFFF, 1'b1);
      drive(1'b1, 16'hFFFF, 1'b1);
      drive(1'b1, 16'h0001, 1'b1);
      drive(1'b1, 16'h0000, 1'b1);
      idle(2);
      chk("u1_minus1", 64'(gen[1].last_out), 64'h3FFFF);
      chk("u0_mixed", 64'(gen[0].last_out), 64'h1FFFF);
      for (int i = 0; i < 4; i++) drive(1'b1, 16'(100 + i), 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, 16'(200 + i), 1'b0);
      drive(1'b1, 16'd300, 1'b0);
      drive(1'b1, 16'd300, 1'b0);
      chk("bp_stall", 64'(gen[0].rdy), 64'(0));
      chk("bp_first_sum", 64'(gen[0].dd), 64'd406);
      drive(1'b1, 16'd300, 1'b1);
      drive(1'b0, 16'd0, 1'b0);
      chk("bp_second_valid", 64'(gen[0].vld), 64'(1));
      chk("bp_second_sum", 64'(gen[0].dd), 64'd903);
      idle(2);
      n0 = gen[0].nout;
      repeat (40) drive(1'b1, 16'($urandom), 1'b1);
      idle(2);
      chk("throughput_outputs", 64'(gen[0].nout - n0), 64'd10);
      drive(1'b1, 16'd5, 1'b1);
      drive(1'b1, 16'd5, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) drive(1'b1, 16'd7, 1'b1);
      idle(2);
      chk("u0_after_reset", 64'(gen[0].last_out), 64'd28);
      chk("u1_after_reset", 64'(gen[1].last_out), 64'd28);
      repeat (1000) drive(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3) != 0);
      idle(4);
      chk("u0_drained", 64'(gen[0].q.size()), 64'd0);
      chk("u1_drained", 64'(gen[1].q.size()), 64'd0);
      chk("u2_drained", 64'(gen[2].q.size()), 64'd0);
      chk("u3_drained", 64'(gen[3].q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
      $finish;
   end
endmodule
